sar_scan_ctrl: RTL and testbench
================================

// Module: sar_scan_ctrl
// PURPOSE
// - Multi-channel SAR conversion controller. Next generation of the single-channel SAR register.
// - Drives an external analog mux, sample/hold switch, binary-weighted DAC and clocked comparator.
// - Scans a programmable channel mask, once or continuously.
// - Delivers tagged results over a valid/ready output port with overrun detection.
// PARAMETERS
// - SIZE      8  DAC / result width in bits (>=2)
// - NCH       4  number of analog channels (>=1); CW = max(1,$clog2(NCH))
// - SETTLE    2  cycles sample is held high before each conversion (>=1)
// - AVG_LOG2  2  log2 of conversions averaged per channel (used only with SAR_AVG_EN)
// PORTS
// - clk         in   1     clock; all state on rising edge
// - rst_n       in   1     asynchronous active-low reset
// - start       in   1     starts a scan; honoured only in IDLE
// - cont        in   1     1 = restart scan after last channel of the round
// - ch_mask     in   NCH   channels to convert; latched on accepted start
// - cmp         in   1     comparator: 1 = Vin >= Vdac
// - dac         out  SIZE  DAC code under trial
// - dacn        out  SIZE  ~dac, for active-low DAC
// - sample      out  1     sample/hold switch closed
// - ch_sel      out  CW    analog mux select
// - clkn        out  1     ~clk, for the clocked comparator
// - busy        out  1     state != IDLE
// - data        out  SIZE  conversion result
// - data_ch     out  CW    channel of data
// - data_valid  out  1     data/data_ch valid
// - data_ready  in   1     consumer accepts when data_valid & data_ready
// - overrun     out  1     sticky: a result was dropped
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE, dac=1<<(SIZE-1), dacn=~dac, sample=0, ch_sel=0, busy=0.
//   - data=0, data_ch=0, data_valid=0, overrun=0; takes effect mid-scan too.
// - States:
//   - IDLE -> SAMPLE on start & |ch_mask.
//   - start with ch_mask==0 is ignored.
//   - Accepted start clears overrun, latches mask and selects its lowest set bit.
// - SAMPLE (SETTLE cycles):
//   - sample=1, ch_sel stable, dac=1<<(SIZE-1).
//   - Then CONV, with shift=MSB and result=MSB.
// - CONV (SIZE cycles), each cycle:
//   - result <= (result | shift>>1) & (cmp ? '1 : ~shift); shift <= shift>>1.
//   - Leave CONV when shift==1 -> STORE.
// - STORE (1 cycle):
//   - Pushes result to the output register.
//   - Then SAMPLE for the next set mask bit (ascending, cleared bits skipped).
//   - After the highest set bit: cont=1 wraps to the lowest set bit; cont=0 goes to IDLE.
//   - cont is sampled only at this point.
// - Latency: data_valid rises SETTLE+SIZE+1 cycles after the accepted start edge.
//   - Each further channel takes the same count.
// - Output handshake:
//   - data/data_ch/data_valid are registered.
//   - Held stable while data_valid & ~data_ready.
//   - Transfer clears data_valid unless a push happens in the same cycle.
// - Push with data_valid=0, or data_valid & data_ready in the same cycle:
//   - New result is loaded and data_valid=1; no overrun.
// - Push with data_valid & ~data_ready:
//   - New result is dropped, old data is kept, overrun <= 1.
// - dac=result at all times; dacn=~dac; clkn=~clk (combinational).
// - Mask changes while busy have no effect until the next accepted start.
// CONFIGURATION
// - SAR_AVG_EN defined:
//   - Each channel is converted 2^AVG_LOG2 times back-to-back, each with a full SAMPLE phase.
//   - Results are summed in a (SIZE+AVG_LOG2)-bit accumulator, cleared at channel start.
//   - Pushed data = sum>>AVG_LOG2 (truncate).
//   - Per-channel latency = 2^AVG_LOG2*(SETTLE+SIZE)+1.
// - SAR_AVG_EN undefined:
//   - Single conversion per channel; AVG_LOG2 is ignored; no accumulator logic.
// TESTING (SIZE=8, NCH=4, SETTLE=2; cmp model: cmp = Vin[ch] >= dac)
// - Single scan:
//   - Stimulus: ch_mask=4'b0001, Vin0=8'hA5, data_ready=1, pulse start.
//   - Required: data_valid at cycle 11, data=8'hA5, data_ch=0, busy drops after STORE.
// - Sparse mask:
//   - Stimulus: ch_mask=4'b1010, Vin1=8'h00, Vin3=8'hFF.
//   - Required: results (ch1,8'h00) then (ch3,8'hFF), 11 cycles apart; ch 0/2 never selected.
// - Continuous wrap:
//   - Stimulus: cont=1, mask=4'b0011.
//   - Required: sequence ch0,ch1,ch0,ch1...; drop cont -> exactly one more round ends on ch1, then IDLE.
// - Backpressure:
//   - Stimulus: data_ready=0 over two pushes.
//   - Required: first result held, second dropped, overrun=1.
//   - Next accepted start clears overrun.
// - Async reset mid-CONV:
//   - Stimulus: rst_n=0.
//   - Required: immediately dac=8'h80, data_valid=0, busy=0; no push after release until start.
// - SAR_AVG_EN, AVG_LOG2=2:
//   - Stimulus: Vin alternating 8'h10/8'h13 per conversion.
//   - Required: data=8'h11 after 4*(2+8)+1=41 cycles.

Source files
------------

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel SAR conversion controller.
// Scans a latched channel mask once or continuously. For each channel it
// holds sample/hold closed for SETTLE cycles and then runs a SIZE-cycle
// binary search against an external clocked comparator. Results leave
// through a registered valid/ready port with sticky overrun detection.
// Optional feature macro: SAR_AVG_EN (average 2^AVG_LOG2 conversions per
// channel; with the macro undefined, one conversion per channel).
module sar_scan_ctrl #(
   parameter int SIZE     = 8,
   parameter int NCH      = 4,
   parameter int SETTLE   = 2,
   parameter int AVG_LOG2 = 2,
   localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            cont,
   input  logic [NCH-1:0]  ch_mask,
   input  logic            cmp,
   output logic [SIZE-1:0] dac,
   output logic [SIZE-1:0] dacn,
   output logic            sample,
   output logic [CW-1:0]   ch_sel,
   output logic            clkn,
   output logic            busy,
   output logic [SIZE-1:0] data,
   output logic [CW-1:0]   data_ch,
   output logic            data_valid,
   input  logic            data_ready,
   output logic            overrun
);

   localparam int SCW = $clog2(SETTLE + 1);
   localparam logic [SIZE-1:0] MSB = {1'b1, {(SIZE-1){1'b0}}};

   // Reject parameter sets the datapath cannot represent.
   if (SIZE < 2 || NCH < 1 || SETTLE < 1 || AVG_LOG2 < 0) begin : g_param_chk
      $error("sar_scan_ctrl: illegal parameter value");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SAMPLE,
      S_CONV,
      S_STORE
   } state_e;

   state_e          state_q, state_d;
   logic [NCH-1:0]  mask_q, mask_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic [SIZE-1:0] shift_q, shift_d;
   logic [SIZE-1:0] result_q, result_d;
   logic [SCW-1:0]  cnt_q, cnt_d;
   logic [SIZE-1:0] data_q, data_d;
   logic [CW-1:0]   data_ch_q, data_ch_d;
   logic            valid_q, valid_d;
   logic            ovr_q, ovr_d;

   logic [SIZE-1:0] conv_res;
   logic [SIZE-1:0] push_val;
   logic            push;
   logic [CW-1:0]   first_start;
   logic [CW-1:0]   first_mask;
   logic [CW-1:0]   next_ch;
   logic            has_next;

`ifdef SAR_AVG_EN
   localparam int ACCW  = SIZE + AVG_LOG2;
   localparam int ACW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int AVG_N = 1 << AVG_LOG2;

   logic [ACCW-1:0] acc_q, acc_d;
   logic [ACW-1:0]  avg_q, avg_d;

   assign push_val = acc_q[ACCW-1:AVG_LOG2];
`else
   assign push_val = result_q;
`endif

   // Channel search: lowest set bit of the incoming mask (start), lowest set
   // bit of the latched mask (wrap) and next set bit above the current channel.
   always_comb begin
      first_start = '0;
      first_mask  = '0;
      next_ch     = '0;
      has_next    = 1'b0;
      for (int unsigned i = NCH; i > 0; i--) begin
         if (ch_mask[i-1]) first_start = CW'(i - 1);
         if (mask_q[i-1])  first_mask  = CW'(i - 1);
         if (mask_q[i-1] && ((i - 1) > 32'(ch_q))) begin
            next_ch  = CW'(i - 1);
            has_next = 1'b1;
         end
      end
   end

   // Next-state logic for the scan FSM, SAR datapath and output port.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      ch_d      = ch_q;
      shift_d   = shift_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      data_ch_d = data_ch_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      push      = 1'b0;
      conv_res  = (result_q | (shift_q >> 1)) & (cmp ? '1 : ~shift_q);
`ifdef SAR_AVG_EN
      acc_d     = acc_q;
      avg_d     = avg_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start && (|ch_mask)) begin
               state_d  = S_SAMPLE;
               mask_d   = ch_mask;
               ch_d     = first_start;
               ovr_d    = 1'b0;
               result_d = MSB;
               cnt_d    = '0;
`ifdef SAR_AVG_EN
               acc_d    = '0;
               avg_d    = '0;
`endif
            end
         end

         S_SAMPLE: begin
            if (cnt_q == SCW'(SETTLE - 1)) begin
               state_d  = S_CONV;
               cnt_d    = '0;
               shift_d  = MSB;
               result_d = MSB;
            end else begin
               cnt_d = cnt_q + SCW'(1);
            end
         end

         S_CONV: begin
            result_d = conv_res;
            shift_d  = shift_q >> 1;
            if (shift_q == SIZE'(1)) begin
`ifdef SAR_AVG_EN
               // The final bit decision is folded into the sum on the same
               // edge, so a repeat conversion can start SAMPLE immediately.
               acc_d = acc_q + ACCW'(conv_res);
               if (avg_q == ACW'(AVG_N - 1)) begin
                  state_d = S_STORE;
               end else begin
                  avg_d    = avg_q + ACW'(1);
                  state_d  = S_SAMPLE;
                  result_d = MSB;
               end
`else
               state_d = S_STORE;
`endif
            end
         end

         S_STORE: begin
            push = 1'b1;
            if (has_next || cont) begin
               state_d  = S_SAMPLE;
               ch_d     = has_next ? next_ch : first_mask;
               result_d = MSB;
               cnt_d    = '0;
`ifdef SAR_AVG_EN
               acc_d    = '0;
               avg_d    = '0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (push) begin
         if (!valid_q || data_ready) begin
            data_d    = push_val;
            data_ch_d = ch_q;
            valid_d   = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mask_q    <= '0;
         ch_q      <= '0;
         shift_q   <= '0;
         result_q  <= MSB;
         cnt_q     <= '0;
         data_q    <= '0;
         data_ch_q <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         ch_q      <= ch_d;
         shift_q   <= shift_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         data_ch_q <= data_ch_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
      end
   end

`ifdef SAR_AVG_EN
   // Averaging accumulator and per-channel conversion counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         avg_q <= '0;
      end else begin
         acc_q <= acc_d;
         avg_q <= avg_d;
      end
   end
`endif

   assign dac        = result_q;
   assign dacn       = ~result_q;
   assign sample     = (state_q == S_SAMPLE);
   assign ch_sel     = ch_q;
   assign clkn       = ~clk;
   assign busy       = (state_q != S_IDLE);
   assign data       = data_q;
   assign data_ch    = data_ch_q;
   assign data_valid = valid_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: directed bench for sar_scan_ctrl (SIZE=8, NCH=4, SETTLE=2).
// The comparator is modelled as cmp = vin[ch_sel] >= dac.
module tb_sar_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       cont;
   logic [3:0] ch_mask;
   logic       cmp;
   logic [7:0] dac, dacn;
   logic       sample;
   logic [1:0] ch_sel;
   logic       clkn;
   logic       busy;
   logic [7:0] data;
   logic [1:0] data_ch;
   logic       data_valid;
   logic       data_ready;
   logic       overrun;

   logic [7:0] vin [4];

   int n_tests = 0;
   int n_fail  = 0;
   int bad_sel = 0;
   logic watch_sel = 1'b0;
   int n;

   sar_scan_ctrl #(
      .SIZE    (8),
      .NCH     (4),
      .SETTLE  (2),
      .AVG_LOG2(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cont      (cont),
      .ch_mask   (ch_mask),
      .cmp       (cmp),
      .dac       (dac),
      .dacn      (dacn),
      .sample    (sample),
      .ch_sel    (ch_sel),
      .clkn      (clkn),
      .busy      (busy),
      .data      (data),
      .data_ch   (data_ch),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   assign cmp = (vin[ch_sel] >= dac);

   // Flag any visit to channels 0 or 2 during the sparse-mask scan.
   always @(negedge clk) begin
      if (watch_sel && busy && (ch_sel == 2'd0 || ch_sel == 2'd2)) bad_sel = bad_sel + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(input int maxc, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!data_valid && cyc < maxc);
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      cont       = 1'b0;
      ch_mask    = 4'b0000;
      data_ready = 1'b1;
      vin[0] = 8'h00; vin[1] = 8'h00; vin[2] = 8'h00; vin[3] = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_dac", dac, 8'h80);
      check("rst_dacn", dacn, 8'h7F);
      check("rst_sample", sample, 0);
      check("rst_ch_sel", ch_sel, 0);
      check("rst_busy", busy, 0);
      check("rst_data", data, 0);
      check("rst_data_ch", data_ch, 0);
      check("rst_valid", data_valid, 0);
      check("rst_overrun", overrun, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Start with an empty mask is ignored
      ch_mask = 4'b0000;
      pulse_start();
      check("mask0_busy", busy, 0);
      check("mask0_sample", sample, 0);

      // Single scan
      ch_mask = 4'b0001;
      vin[0]  = 8'hA5;
      pulse_start();
      check("single_sample", sample, 1);
      check("single_dac_hold", dac, 8'h80);
      wait_valid(20, n);
      check("single_latency", n, 11);
      check("single_data", data, 8'hA5);
      check("single_ch", data_ch, 0);
      check("single_busy_end", busy, 0);
      @(posedge clk);
      #1;
      check("single_valid_clr", data_valid, 0);

      // Sparse mask; mask change while busy must not matter
      ch_mask = 4'b1010;
      vin[1]  = 8'h00;
      vin[3]  = 8'hFF;
      watch_sel = 1'b1;
      pulse_start();
      ch_mask = 4'b1111;
      wait_valid(20, n);
      check("sparse_lat1", n, 11);
      check("sparse_ch1", data_ch, 1);
      check("sparse_data1", data, 8'h00);
      wait_valid(20, n);
      check("sparse_gap", n, 11);
      check("sparse_ch3", data_ch, 3);
      check("sparse_data3", data, 8'hFF);
      check("sparse_busy_end", busy, 0);
      watch_sel = 1'b0;
      check("sparse_no_sel02", bad_sel, 0);

      // Continuous wrap
      ch_mask = 4'b0011;
      vin[0]  = 8'h3C;
      vin[1]  = 8'hC3;
      cont    = 1'b1;
      pulse_start();
      for (int r = 0; r < 4; r++) begin
         wait_valid(20, n);
         check("cont_gap", n, 11);
         check("cont_ch", data_ch, r % 2);
         check("cont_data", data, (r % 2 == 0) ? 8'h3C : 8'hC3);
      end
      cont = 1'b0;
      wait_valid(20, n);
      check("cont_tail_ch0", data_ch, 0);
      check("cont_tail_busy0", busy, 1);
      wait_valid(20, n);
      check("cont_tail_ch1", data_ch, 1);
      check("cont_tail_data1", data, 8'hC3);
      check("cont_idle", busy, 0);
      wait_valid(25, n);
      check("cont_quiet_valid", data_valid, 0);
      check("cont_quiet_busy", busy, 0);

      // Backpressure and overrun
      data_ready = 1'b0;
      ch_mask    = 4'b0011;
      vin[0]     = 8'h55;
      vin[1]     = 8'hAA;
      pulse_start();
      wait_valid(20, n);
      check("bp_lat", n, 11);
      check("bp_data1", data, 8'h55);
      check("bp_ovr_before", overrun, 0);
      repeat (11) @(posedge clk);
      #1;
      check("bp_hold_data", data, 8'h55);
      check("bp_hold_ch", data_ch, 0);
      check("bp_hold_valid", data_valid, 1);
      check("bp_overrun", overrun, 1);
      check("bp_idle", busy, 0);
      @(negedge clk);
      data_ready = 1'b1;
      @(posedge clk);
      #1;
      data_ready = 1'b0;
      check("bp_drain", data_valid, 0);
      check("bp_ovr_sticky", overrun, 1);
      ch_mask = 4'b0001;
      vin[0]  = 8'h5A;
      pulse_start();
      check("bp_ovr_clear", overrun, 0);
      wait_valid(20, n);
      check("bp_restart_data", data, 8'h5A);

      // Async reset mid-conversion (previous result still pending)
      pulse_start();
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_dac", dac, 8'h80);
      check("arst_valid", data_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_sample", sample, 0);
      @(negedge clk);
      rst_n      = 1'b1;
      data_ready = 1'b1;
      wait_valid(30, n);
      check("arst_no_push", data_valid, 0);
      check("arst_idle", busy, 0);
      check("arst_data", data, 0);

`ifdef SAR_AVG_EN
      // Averaging: four conversions alternating 0x10 / 0x13 -> 0x11
      ch_mask = 4'b0001;
      vin[0]  = 8'h10;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         vin[0] = (k % 2 == 0) ? 8'h10 : 8'h13;
         repeat (10) @(posedge clk);
         #1;
      end
      wait_valid(5, n);
      check("avg_lat_tail", n, 1);
      check("avg_data", data, 8'h11);
      check("avg_ch", data_ch, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
